// File: rtl/core_hazard_pkg.sv
// Shared encodings for the Selen 5-stage hazard controller: EXE command
// classes, stage enable/kill bit positions, forwarding selects and the
// multi-cycle sequencer state type.
package core_hazard_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_JUMP  = 2'd1,
        CMD_BRNCH = 2'd2,
        CMD_MCYC  = 2'd3
    } exe_cmd_e;

    // enb_out bit positions
    localparam int unsigned ENB_PC      = 0;
    localparam int unsigned ENB_IF_DEC  = 1;
    localparam int unsigned ENB_DEC_EXE = 2;
    localparam int unsigned ENB_EXE_MEM = 3;
    localparam int unsigned ENB_MEM_WB  = 4;

    // kill_out bit positions
    localparam int unsigned KILL_IF_DEC  = 0;
    localparam int unsigned KILL_DEC_EXE = 1;
    localparam int unsigned KILL_EXE_MEM = 2;
    localparam int unsigned KILL_MEM_WB  = 3;

    // EXE operand forwarding selects
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_MCYC = 1'b1
    } mcyc_state_e;

endpackage

// File: rtl/core_hazard_fwd.sv
// Forwarding compare logic: selects the youngest in-flight producer for the
// EXE operands and for MEM store data. Pure combinational; register 0 is
// never forwarded because it is hardwired to zero.
module core_hazard_fwd
    import core_hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_exe_rs1,
    input  logic [REG_AW-1:0] i_exe_rs2,
    input  logic              i_mem_valid,
    input  logic              i_mem_we,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic [REG_AW-1:0] i_mem_rs2,
    input  logic              i_mem_is_store,
    input  logic              i_wb_valid,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    output logic [1:0]        o_fwd_exe_rs1,
    output logic [1:0]        o_fwd_exe_rs2,
    output logic              o_fwd_mem_rs2
);

    // MEM is younger than WB, so it takes precedence when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              mem_hit_en,
        input logic [REG_AW-1:0] mem_rd,
        input logic              wb_hit_en,
        input logic [REG_AW-1:0] wb_rd
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rs == '0) begin
            sel = FWD_RF;
        end else if (mem_hit_en && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_hit_en && (wb_rd == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    logic w_mem_wr;
    logic w_wb_wr;

    assign w_mem_wr = i_mem_valid & i_mem_we;
    assign w_wb_wr  = i_wb_valid & i_wb_we;

    // Operand and store-data bypass selection.
    always_comb begin
        o_fwd_exe_rs1 = fwd_sel(i_exe_rs1, w_mem_wr, i_mem_rd, w_wb_wr, i_wb_rd);
        o_fwd_exe_rs2 = fwd_sel(i_exe_rs2, w_mem_wr, i_mem_rd, w_wb_wr, i_wb_rd);
        if (i_mem_valid && i_mem_is_store && w_wb_wr &&
            (i_wb_rd == i_mem_rs2) && (i_mem_rs2 != '0)) begin
            o_fwd_mem_rs2 = 1'b1;
        end else begin
            o_fwd_mem_rs2 = 1'b0;
        end
    end

endmodule

// File: rtl/core_hazard_unit_p.sv
// Hazard controller for the Selen pipeline: stage enables/kills, PC source,
// bypass selects, multi-cycle EXE sequencing and a saturating count of
// cycles in which the PC did not advance.
module core_hazard_unit_p
    import core_hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned MCYC_LAT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic              dec_use_rs1,
    input  logic              dec_use_rs2,
    input  logic              exe_valid,
    input  logic [1:0]        exe_cmd,
    input  logic              exe_is_load,
    input  logic              exe_we,
    input  logic [REG_AW-1:0] exe_rd,
    input  logic [REG_AW-1:0] exe_rs1,
    input  logic [REG_AW-1:0] exe_rs2,
    input  logic              brnch_tkn,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] mem_rs2,
    input  logic              mem_is_store,
    input  logic              wb_valid,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              imem_stall,
    input  logic              dmem_stall,
    input  logic              stat_clr,
    output logic [4:0]        enb_out,
    output logic [3:0]        kill_out,
    output logic              pc_sel_out,
    output logic [1:0]        fwd_exe_rs1_out,
    output logic [1:0]        fwd_exe_rs2_out,
    output logic              fwd_mem_rs2_out,
    output logic              mcyc_busy_out,
    output logic [CNT_W-1:0]  stall_cnt_out
);

    // Counter only needs to hold MCYC_LAT-2; a latency of 1 never stalls.
    localparam int unsigned CW          = (MCYC_LAT > 2) ? $clog2(MCYC_LAT) : 1;
    localparam int          MCYC_INIT_I = (MCYC_LAT > 1) ? (int'(MCYC_LAT) - 2) : 0;
    localparam logic [CW-1:0] MCYC_INIT = CW'(MCYC_INIT_I);
    localparam logic        MCYC_EN     = (MCYC_LAT > 1) ? 1'b1 : 1'b0;

    mcyc_state_e        r_state;
    logic [CW-1:0]      r_mcyc_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_mcyc_start;
    logic               w_mcyc_stall;
    logic               w_redirect;
    logic               w_load_use;
    logic [4:0]         w_enb;
    logic [3:0]         w_kill;
    logic               w_pc_sel;
    logic [1:0]         w_fwd_rs1;
    logic [1:0]         w_fwd_rs2;
    logic               w_fwd_mem;

    core_hazard_fwd #(
        .REG_AW (REG_AW)
    ) u_fwd (
        .i_exe_rs1      (exe_rs1),
        .i_exe_rs2      (exe_rs2),
        .i_mem_valid    (mem_valid),
        .i_mem_we       (mem_we),
        .i_mem_rd       (mem_rd),
        .i_mem_rs2      (mem_rs2),
        .i_mem_is_store (mem_is_store),
        .i_wb_valid     (wb_valid),
        .i_wb_we        (wb_we),
        .i_wb_rd        (wb_rd),
        .o_fwd_exe_rs1  (w_fwd_rs1),
        .o_fwd_exe_rs2  (w_fwd_rs2),
        .o_fwd_mem_rs2  (w_fwd_mem)
    );

    assign w_mcyc_start = exe_valid & (exe_cmd_e'(exe_cmd) == CMD_MCYC) & MCYC_EN;

    assign w_redirect = exe_valid &
                        ((exe_cmd_e'(exe_cmd) == CMD_JUMP) |
                         ((exe_cmd_e'(exe_cmd) == CMD_BRNCH) & brnch_tkn));

    assign w_load_use = exe_valid & exe_is_load & exe_we & (exe_rd != '0) & dec_valid &
                        ((dec_use_rs1 & (dec_rs1 == exe_rd)) |
                         (dec_use_rs2 & (dec_rs2 == exe_rd)));

    // Multi-cycle stall: raised on the first EXE cycle of the op and while
    // cycles remain; the cycle where the counter reads zero releases the op.
    always_comb begin
        w_mcyc_stall = 1'b0;
        case (r_state)
            ST_RUN:  w_mcyc_stall = w_mcyc_start;
            ST_MCYC: w_mcyc_stall = (r_mcyc_cnt != '0);
            default: w_mcyc_stall = 1'b0;
        endcase
    end

    // Multi-cycle sequencer; a data-cache miss freezes it so the op keeps
    // its full number of useful EXE cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_mcyc_cnt <= '0;
        end else if (dmem_stall) begin
            r_state    <= r_state;
            r_mcyc_cnt <= r_mcyc_cnt;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mcyc_start) begin
                        r_state    <= ST_MCYC;
                        r_mcyc_cnt <= MCYC_INIT;
                    end else begin
                        r_state    <= ST_RUN;
                        r_mcyc_cnt <= r_mcyc_cnt;
                    end
                end
                ST_MCYC: begin
                    if (r_mcyc_cnt != '0) begin
                        r_state    <= ST_MCYC;
                        r_mcyc_cnt <= r_mcyc_cnt - CW'(1);
                    end else begin
                        r_state    <= ST_RUN;
                        r_mcyc_cnt <= r_mcyc_cnt;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_mcyc_cnt <= '0;
                end
            endcase
        end
    end

    // Stall priority: reset, data miss, multi-cycle, redirect, load-use,
    // instruction miss. Only the highest active condition shapes the outputs.
    always_comb begin
        w_enb    = 5'h1F;
        w_kill   = 4'h0;
        w_pc_sel = 1'b0;
        if (!rst_n) begin
            w_enb  = 5'h00;
            w_kill = 4'hF;
        end else if (dmem_stall) begin
            w_enb  = 5'h00;
            w_kill = 4'h0;
        end else if (w_mcyc_stall) begin
            w_enb[ENB_PC]          = 1'b0;
            w_enb[ENB_IF_DEC]      = 1'b0;
            w_enb[ENB_DEC_EXE]     = 1'b0;
            w_kill[KILL_EXE_MEM]   = 1'b1;
        end else if (w_redirect) begin
            w_pc_sel               = 1'b1;
            w_kill[KILL_IF_DEC]    = 1'b1;
            w_kill[KILL_DEC_EXE]   = 1'b1;
        end else if (w_load_use) begin
            w_enb[ENB_PC]          = 1'b0;
            w_enb[ENB_IF_DEC]      = 1'b0;
            w_kill[KILL_DEC_EXE]   = 1'b1;
        end else if (imem_stall) begin
            w_enb[ENB_PC]          = 1'b0;
            w_kill[KILL_IF_DEC]    = 1'b1;
        end else begin
            w_enb    = 5'h1F;
            w_kill   = 4'h0;
            w_pc_sel = 1'b0;
        end
    end

    // Saturating count of cycles in which the PC was held; clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stat_clr) begin
            r_stall_cnt <= '0;
        end else if (!w_enb[ENB_PC] && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign enb_out         = w_enb;
    assign kill_out        = w_kill;
    assign pc_sel_out      = w_pc_sel;
    assign fwd_exe_rs1_out = rst_n ? w_fwd_rs1 : FWD_RF;
    assign fwd_exe_rs2_out = rst_n ? w_fwd_rs2 : FWD_RF;
    assign fwd_mem_rs2_out = rst_n & w_fwd_mem;
    assign mcyc_busy_out   = rst_n & w_mcyc_stall;
    assign stall_cnt_out   = r_stall_cnt;

endmodule

// File: tb/tb_core_hazard_unit_p.sv
// Directed bench for core_hazard_unit_p. Expected outputs are queued when a
// step is driven and compared at the following falling edge.
module tb_core_hazard_unit_p;

    localparam int unsigned AW  = 5;
    localparam int unsigned CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dec_valid, dec_use_rs1, dec_use_rs2;
    logic [AW-1:0] dec_rs1, dec_rs2;
    logic          exe_valid, exe_is_load, exe_we;
    logic [1:0]    exe_cmd;
    logic [AW-1:0] exe_rd, exe_rs1, exe_rs2;
    logic          brnch_tkn;
    logic          mem_valid, mem_we, mem_is_store;
    logic [AW-1:0] mem_rd, mem_rs2;
    logic          wb_valid, wb_we;
    logic [AW-1:0] wb_rd;
    logic          imem_stall, dmem_stall, stat_clr;

    logic [4:0]    enb_out, enb1;
    logic [3:0]    kill_out, kill1;
    logic          pc_sel_out, pc1;
    logic [1:0]    fwd_exe_rs1_out, fwd_exe_rs2_out, f1_1, f2_1;
    logic          fwd_mem_rs2_out, fm1;
    logic          mcyc_busy_out, busy1;
    logic [CW-1:0] stall_cnt_out;
    logic [15:0]   stall_cnt1;

    always #5 clk = ~clk;

    core_hazard_unit_p #(.REG_AW(AW), .MCYC_LAT(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .exe_valid(exe_valid), .exe_cmd(exe_cmd), .exe_is_load(exe_is_load),
        .exe_we(exe_we), .exe_rd(exe_rd), .exe_rs1(exe_rs1), .exe_rs2(exe_rs2),
        .brnch_tkn(brnch_tkn),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_rs2(mem_rs2), .mem_is_store(mem_is_store),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .stat_clr(stat_clr),
        .enb_out(enb_out), .kill_out(kill_out), .pc_sel_out(pc_sel_out),
        .fwd_exe_rs1_out(fwd_exe_rs1_out), .fwd_exe_rs2_out(fwd_exe_rs2_out),
        .fwd_mem_rs2_out(fwd_mem_rs2_out), .mcyc_busy_out(mcyc_busy_out),
        .stall_cnt_out(stall_cnt_out)
    );

    // Second instance with single-cycle multi-cycle latency: never busy.
    core_hazard_unit_p #(.REG_AW(AW), .MCYC_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .exe_valid(exe_valid), .exe_cmd(exe_cmd), .exe_is_load(exe_is_load),
        .exe_we(exe_we), .exe_rd(exe_rd), .exe_rs1(exe_rs1), .exe_rs2(exe_rs2),
        .brnch_tkn(brnch_tkn),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_rs2(mem_rs2), .mem_is_store(mem_is_store),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .stat_clr(stat_clr),
        .enb_out(enb1), .kill_out(kill1), .pc_sel_out(pc1),
        .fwd_exe_rs1_out(f1_1), .fwd_exe_rs2_out(f2_1),
        .fwd_mem_rs2_out(fm1), .mcyc_busy_out(busy1),
        .stall_cnt_out(stall_cnt1)
    );

    typedef struct {
        string      tag;
        logic [4:0] enb;
        logic [3:0] kill;
        logic       pc;
        logic [1:0] f1;
        logic [1:0] f2;
        logic       fm;
        logic       busy;
    } exp_t;

    exp_t          sb_q[$];
    int            n_pass  = 0;
    int            n_total = 0;
    logic [CW-1:0] exp_cnt = '0;

    task automatic check(input string tag, input string fld,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    endtask

    task automatic clear_in();
        dec_valid = 1'b0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
        dec_rs1 = '0; dec_rs2 = '0;
        exe_valid = 1'b0; exe_is_load = 1'b0; exe_we = 1'b0; exe_cmd = 2'd0;
        exe_rd = '0; exe_rs1 = '0; exe_rs2 = '0; brnch_tkn = 1'b0;
        mem_valid = 1'b0; mem_we = 1'b0; mem_is_store = 1'b0;
        mem_rd = '0; mem_rs2 = '0;
        wb_valid = 1'b0; wb_we = 1'b0; wb_rd = '0;
        imem_stall = 1'b0; dmem_stall = 1'b0; stat_clr = 1'b0;
    endtask

    // Queue the expectation for the currently driven inputs, then compare at
    // the falling edge and advance to just after the next rising edge.
    task automatic step(input string tag, input logic [4:0] enb, input logic [3:0] kill,
                        input logic pc, input logic [1:0] f1, input logic [1:0] f2,
                        input logic fm, input logic busy);
        exp_t e;
        e.tag = tag; e.enb = enb; e.kill = kill; e.pc = pc;
        e.f1 = f1; e.f2 = f2; e.fm = fm; e.busy = busy;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check(e.tag, "enb",  32'(enb_out),         32'(e.enb));
        check(e.tag, "kill", 32'(kill_out),        32'(e.kill));
        check(e.tag, "pc",   32'(pc_sel_out),      32'(e.pc));
        check(e.tag, "f1",   32'(fwd_exe_rs1_out), 32'(e.f1));
        check(e.tag, "f2",   32'(fwd_exe_rs2_out), 32'(e.f2));
        check(e.tag, "fm",   32'(fwd_mem_rs2_out), 32'(e.fm));
        check(e.tag, "busy", 32'(mcyc_busy_out),   32'(e.busy));
        check(e.tag, "cnt",  32'(stall_cnt_out),   32'(exp_cnt));
        check(e.tag, "busy_lat1", 32'(busy1),      32'(1'b0));
        if (!rst_n) begin
            exp_cnt = '0;
        end else if (stat_clr) begin
            exp_cnt = '0;
        end else if (!e.enb[0] && exp_cnt != {CW{1'b1}}) begin
            exp_cnt = exp_cnt + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        @(posedge clk);
        #1;
        step("rst0", 5'h00, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        mem_valid = 1'b1; mem_we = 1'b1; mem_rd = 5'd5; exe_rs1 = 5'd5;
        step("rst_fwd", 5'h00, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

        rst_n = 1'b1;
        clear_in();
        step("idle", 5'h1F, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

        // Forwarding
        mem_valid = 1'b1; mem_we = 1'b1; mem_rd = 5'd5;
        wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd5;
        exe_rs1 = 5'd5; exe_rs2 = 5'd0;
        step("fwd_mem_wins", 5'h1F, 4'h0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0);
        mem_we = 1'b0; exe_rs2 = 5'd5;
        step("fwd_wb", 5'h1F, 4'h0, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0);
        wb_rd = 5'd0; exe_rs1 = 5'd0; exe_rs2 = 5'd0;
        step("fwd_r0", 5'h1F, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        clear_in();
        mem_valid = 1'b1; mem_is_store = 1'b1; mem_rs2 = 5'd9;
        wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd9; exe_rs1 = 5'd9;
        step("fwd_store", 5'h1F, 4'h0, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0);
        mem_valid = 1'b0;
        step("fwd_store_nomem", 5'h1F, 4'h0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0);

        // Load-use
        clear_in();
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_we = 1'b1; exe_rd = 5'd7;
        dec_valid = 1'b1; dec_use_rs2 = 1'b1; dec_rs2 = 5'd7;
        step("load_use", 5'h1C, 4'h2, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        clear_in();
        mem_valid = 1'b1; mem_we = 1'b1; mem_rd = 5'd7;
        exe_valid = 1'b1; exe_rs2 = 5'd7;
        step("load_use_next", 5'h1F, 4'h0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0);
        clear_in();
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_we = 1'b1; exe_rd = 5'd0;
        dec_valid = 1'b1; dec_use_rs1 = 1'b1; dec_rs1 = 5'd0;
        step("load_r0", 5'h1F, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        exe_rd = 5'd7; dec_rs1 = 5'd7; dec_use_rs1 = 1'b0;
        step("load_nouse", 5'h1F, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

        // Multi-cycle op, latency 4
        clear_in();
        exe_valid = 1'b1; exe_cmd = 2'd3;
        step("mcyc_c1", 5'h18, 4'h4, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        imem_stall = 1'b1;
        step("mcyc_c2", 5'h18, 4'h4, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        step("mcyc_c3", 5'h18, 4'h4, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        step("mcyc_rel", 5'h1E, 4'h1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        clear_in();
        step("mcyc_after", 5'h1F, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

        // Redirects
        exe_valid = 1'b1; exe_cmd = 2'd2; brnch_tkn = 1'b1; imem_stall = 1'b1;
        step("br_imem", 5'h1F, 4'h3, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
        brnch_tkn = 1'b0;
        step("br_nt_imem", 5'h1E, 4'h1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        exe_cmd = 2'd1; imem_stall = 1'b0;
        step("jump", 5'h1F, 4'h3, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
        exe_valid = 1'b0;
        step("jump_invalid", 5'h1F, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        exe_valid = 1'b1; exe_cmd = 2'd2; brnch_tkn = 1'b1; dmem_stall = 1'b1;
        step("br_dmem0", 5'h00, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        step("br_dmem1", 5'h00, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        dmem_stall = 1'b0;
        step("br_dmem_rel", 5'h1F, 4'h3, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);

        // Data miss while the multi-cycle counter sits at 1
        clear_in();
        exe_valid = 1'b1; exe_cmd = 2'd3;
        step("mdm_c1", 5'h18, 4'h4, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        step("mdm_c2", 5'h18, 4'h4, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        dmem_stall = 1'b1;
        step("mdm_d1", 5'h00, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        step("mdm_d2", 5'h00, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        dmem_stall = 1'b0;
        step("mdm_c3", 5'h18, 4'h4, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        step("mdm_rel", 5'h1F, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        clear_in();
        step("mdm_after", 5'h1F, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

        // Reset in the middle of a multi-cycle op, then a fresh op
        exe_valid = 1'b1; exe_cmd = 2'd3;
        step("rmid_c1", 5'h18, 4'h4, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        rst_n = 1'b0;
        step("rmid_rst", 5'h00, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step("rmid_n1", 5'h18, 4'h4, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        step("rmid_n2", 5'h18, 4'h4, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        step("rmid_n3", 5'h18, 4'h4, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
        step("rmid_rel", 5'h1F, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        clear_in();

        // Stall statistics: clear, saturate, clear again
        stat_clr = 1'b1;
        step("cnt_clr", 5'h1F, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        stat_clr = 1'b0; imem_stall = 1'b1;
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            step("cnt_imem", 5'h1E, 4'h1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        end
        stat_clr = 1'b1;
        step("cnt_clr_wins", 5'h1E, 4'h1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        clear_in();
        step("cnt_zero", 5'h1F, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        step("cnt_hold", 5'h1F, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
